fpga_reset_sequencer: RTL
=========================

# fpga_reset_sequencer

Parametrised reset sequencer for the FPGA PULPissimo targets. It sits between the board clock/reset pads (and clock-generator lock) and the SoC. It replaces the single fixed reset pulse with per-domain active-low resets. Those resets are held for a minimum time, gated on clock lock, and released in staged order. A run-time soft-reset path re-sequences a selected subset of domains without touching the rest.

## Interface

- NUM_DOMAINS, 3, number of reset domains; legal 1..32
- HOLD_CYCLES, 16, minimum cycles all targeted domains stay in reset after the cause clears; legal >= 1
- STAGE_GAP, 8, cycles between consecutive domain releases; legal >= 1

- ref_clk  in  1  sole clock
- pad_reset  in  1  reset; synchronous, active-high
- pll_locked_i  in  1  clock-generator lock; 0 = clocks not valid
- soft_rst_req_i  in  1  single-cycle soft-reset request
- soft_rst_mask_i  in  NUM_DOMAINS  domains targeted by the soft reset; sampled with the request
- rst_n_o  out  NUM_DOMAINS  per-domain reset, active-low, registered; bit 0 releases first
- seq_done_o  out  1  1 = all domains released and sequencer idle (RUN)
- seq_state_o  out  3  current state encoding: HOLD=0, RELEASE=1, RUN=2, SOFT_HOLD=3, SOFT_RELEASE=4

## Operation

**Reset.** While pad_reset=1, at every edge the block goes to HOLD with counters cleared and the latched mask cleared. Outputs: rst_n_o=0, seq_done_o=0, seq_state_o=0.

**HOLD.**
- All rst_n_o stay 0.
- The hold counter increments only while pll_locked_i=1, and clears when pll_locked_i=0.
- When it reaches HOLD_CYCLES, the block sets rst_n_o[0]=1 and enters RELEASE with domain index 1.

**RELEASE.**
- The gap counter counts STAGE_GAP cycles, then the next domain index is released.
- After the release of bit NUM_DOMAINS-1, the block enters RUN on the next edge with seq_done_o=1.
- With NUM_DOMAINS=1 the block goes directly HOLD → RUN one edge after release.

**RUN.** All rst_n_o=1 and seq_done_o=1.
- If soft_rst_req_i=1 with a nonzero mask, the mask is latched and the masked rst_n_o bits go 0. seq_done_o goes 0, the block enters SOFT_HOLD, and the hold counter clears.
- A zero mask is ignored.

**SOFT_HOLD.**
- The counter behaves as in HOLD.
- At HOLD_CYCLES, the lowest-index masked domain is released and the block enters SOFT_RELEASE.

**SOFT_RELEASE.**
- Remaining masked domains release in ascending index order, STAGE_GAP cycles apart. Unmasked indices are skipped and consume no gap.
- The block returns to RUN one edge after the last masked release.
- Unmasked domains stay 1 throughout the soft sequence.

**Lock loss.** pll_locked_i=0 in RELEASE, RUN, SOFT_HOLD or SOFT_RELEASE is treated as a full reset. On the next edge all rst_n_o=0, seq_done_o=0, the mask is cleared, and the block enters HOLD.

**Priority (highest first):** pad_reset, then lock loss, then soft request. soft_rst_req_i is ignored in every state except RUN.

**Widths.**
- Counters are $clog2(max(HOLD_CYCLES,STAGE_GAP)+1) bits and saturate; they never wrap.
- The index register is $clog2(NUM_DOMAINS+1) bits.

## Timing

- All outputs are registered and change only on ref_clk rising edges; there are no combinational input→output paths.
- **Power-on timing.** Let t0 be the first edge at which pad_reset=0 and pll_locked_i=1.
  - rst_n_o[k] rises at t0+HOLD_CYCLES+k·STAGE_GAP.
  - seq_done_o rises at t0+HOLD_CYCLES+(NUM_DOMAINS-1)·STAGE_GAP+1.
- **Soft reset timing.** Let t1 be the edge that samples the request.
  - Masked bits fall at t1.
  - The j-th masked domain (j from 0) rises at t1+1+HOLD_CYCLES+j·STAGE_GAP.
  - seq_done_o rises one edge after the last masked release.
- A lock drop of even one cycle restarts the full HOLD_CYCLES count.

## Test plan

1. **Power-on.** NUM_DOMAINS=3, HOLD=16, GAP=8, lock=1; pad_reset high 25 cycles, then low at t0 → rst_n_o=000 until t0+16. Then 001 at t0+16, 011 at t0+24, 111 at t0+32; seq_done_o=1 at t0+33; seq_state_o 0→1→2.
2. **Lock gating and lock loss.** lock=0 until t0+10 → all release times shift by +10. Later, in RUN, drop lock for 1 cycle → rst_n_o=000 and seq_done_o=0 on the next edge, followed by a full resequence.
3. **Soft reset, contiguous mask.** In RUN, request with mask 110 at t1 → rst_n_o=001 at t1. Then 011 at t1+17 and 111 at t1+25; seq_done_o=1 at t1+26; bit 0 never drops.
4. **Soft reset, sparse mask.** Mask 101 at t1 → rst_n_o=010 at t1. Bit 0 rises at t1+17, bit 2 at t1+25, with no gap spent on bit 1. Mask 000 → no change. A request in SOFT_HOLD → ignored.
5. **pad_reset mid-RELEASE.** Assert pad_reset when rst_n_o=001 → 000 and state HOLD on the sampling edge. After pad_reset clears, the full sequence repeats with timing as in scenario 1.
6. **Minimal parameters.** NUM_DOMAINS=1, HOLD=1, GAP=1 → rst_n_o rises at t0+1 and seq_done_o at t0+2. A soft request with mask 1 at t1 → low at t1, high at t1+2.

Source files
------------

// File: rtl/fpga_reset_sequencer.sv
// fpga_reset_sequencer
// Per-domain active-low reset generator for the FPGA targets. All domains are
// held in reset for HOLD_CYCLES locked cycles, then released in ascending
// order STAGE_GAP cycles apart. From RUN, a soft request re-sequences only the
// masked domains. Clock-lock loss always forces a full resequence.
module fpga_reset_sequencer #(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic                   ref_clk,
  input  logic                   pad_reset,
  input  logic                   pll_locked_i,
  input  logic                   soft_rst_req_i,
  input  logic [NUM_DOMAINS-1:0] soft_rst_mask_i,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   seq_done_o,
  output logic [2:0]             seq_state_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_DOMAINS + 1);

  // Counters share one width so that a single saturating increment serves both.
  localparam logic [CW-1:0]          HOLD_LAST = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0]          GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0]          CNT_SAT   = CW'(CNT_MAX);
  localparam logic [CW-1:0]          CNT_ZERO  = {CW{1'b0}};
  localparam logic [IW-1:0]          IDX_ONE   = IW'(1'b1);
  localparam logic [IW-1:0]          IDX_END   = IW'(NUM_DOMAINS);
  localparam logic [IW-1:0]          IDX_ZERO  = {IW{1'b0}};
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE   = NUM_DOMAINS'(1'b1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ALL   = {NUM_DOMAINS{1'b1}};
  localparam logic [NUM_DOMAINS-1:0] DOM_NONE  = {NUM_DOMAINS{1'b0}};

  typedef enum logic [2:0] {
    ST_HOLD         = 3'd0,
    ST_RELEASE      = 3'd1,
    ST_RUN          = 3'd2,
    ST_SOFT_HOLD    = 3'd3,
    ST_SOFT_RELEASE = 3'd4
  } state_t;

  state_t                   state_r;
  logic [CW-1:0]            hold_cnt_r;
  logic [CW-1:0]            gap_cnt_r;
  logic [IW-1:0]            idx_r;
  logic [NUM_DOMAINS-1:0]   pend_mask_r;  // soft-reset domains still waiting for release
  logic [NUM_DOMAINS-1:0]   rst_n_r;
  logic                     done_r;

  // Isolate the lowest set bit: the next domain to release in a soft sequence.
  function automatic logic [NUM_DOMAINS-1:0] lowest_one(input logic [NUM_DOMAINS-1:0] v);
    return v & (~v + DOM_ONE);
  endfunction

  // Counter increment that sticks at its maximum instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_SAT) ? c : c + CW'(1'b1);
  endfunction

  // Sequencer FSM: pad reset, then lock loss, then the per-state sequencing.
  always_ff @(posedge ref_clk) begin
    if (pad_reset || !pll_locked_i) begin
      state_r     <= ST_HOLD;
      hold_cnt_r  <= CNT_ZERO;
      gap_cnt_r   <= CNT_ZERO;
      idx_r       <= IDX_ZERO;
      pend_mask_r <= DOM_NONE;
      rst_n_r     <= DOM_NONE;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            rst_n_r   <= DOM_ONE;
            idx_r     <= IDX_ONE;
            gap_cnt_r <= CNT_ZERO;
            state_r   <= ST_RELEASE;
          end else begin
            hold_cnt_r <= sat_inc(hold_cnt_r);
          end
        end
        ST_RELEASE: begin
          // idx_r == NUM_DOMAINS means the last domain went out on the previous edge.
          if (idx_r == IDX_END) begin
            done_r  <= 1'b1;
            state_r <= ST_RUN;
          end else if (gap_cnt_r == GAP_LAST) begin
            rst_n_r   <= rst_n_r | (DOM_ONE << idx_r);
            idx_r     <= idx_r + IDX_ONE;
            gap_cnt_r <= CNT_ZERO;
          end else begin
            gap_cnt_r <= sat_inc(gap_cnt_r);
          end
        end
        ST_RUN: begin
          if (soft_rst_req_i && (soft_rst_mask_i != DOM_NONE)) begin
            pend_mask_r <= soft_rst_mask_i;
            rst_n_r     <= rst_n_r & ~soft_rst_mask_i;
            done_r      <= 1'b0;
            hold_cnt_r  <= CNT_ZERO;
            state_r     <= ST_SOFT_HOLD;
          end else begin
            rst_n_r <= DOM_ALL;
            done_r  <= 1'b1;
          end
        end
        ST_SOFT_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            rst_n_r     <= rst_n_r | lowest_one(pend_mask_r);
            pend_mask_r <= pend_mask_r & ~lowest_one(pend_mask_r);
            gap_cnt_r   <= CNT_ZERO;
            state_r     <= ST_SOFT_RELEASE;
          end else begin
            hold_cnt_r <= sat_inc(hold_cnt_r);
          end
        end
        ST_SOFT_RELEASE: begin
          // Unmasked indices are never in pend_mask_r, so they cost no gap.
          if (pend_mask_r == DOM_NONE) begin
            done_r  <= 1'b1;
            state_r <= ST_RUN;
          end else if (gap_cnt_r == GAP_LAST) begin
            rst_n_r     <= rst_n_r | lowest_one(pend_mask_r);
            pend_mask_r <= pend_mask_r & ~lowest_one(pend_mask_r);
            gap_cnt_r   <= CNT_ZERO;
          end else begin
            gap_cnt_r <= sat_inc(gap_cnt_r);
          end
        end
        default: begin
          state_r     <= ST_HOLD;
          hold_cnt_r  <= CNT_ZERO;
          gap_cnt_r   <= CNT_ZERO;
          idx_r       <= IDX_ZERO;
          pend_mask_r <= DOM_NONE;
          rst_n_r     <= DOM_NONE;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign rst_n_o     = rst_n_r;
  assign seq_done_o  = done_r;
  assign seq_state_o = state_r;

endmodule
